// File: rtl/indarb_pkg.sv
// Shared types and constants for the portal indication arbiter.
// Build option: INDARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
package indarb_pkg;
  localparam int METHOD_W  = 16;
  localparam int PAYLOAD_W = 32;

  localparam logic [31:0] INTR_CHANNEL_NONE = 32'hFFFF_FFFF;

  // Entry layout at the default payload width; the top rebuilds it for its own DW.
  typedef struct packed {
    logic [METHOD_W-1:0]  method;
    logic [PAYLOAD_W-1:0] payload;
  } indarb_entry_t;
endpackage

// File: rtl/indarb_fifo.sv
// Circular buffer shared by all indication sources.
// Pointers and count are reset; the storage array is not.
module indarb_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  // Caller guarantees wr_en only when !full and rd_en only when !empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
endmodule

// File: rtl/portal_indication_arbiter.sv
// Grants one indication source per cycle and queues its tagged word for the portal.
// Build option: INDARB_FIXED_PRIO_EN (lowest index wins, no rotating pointer).
module portal_indication_arbiter
  import indarb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DEPTH = 8,
  parameter int DW    = 32
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [NREQ-1:0]     req_want,
  output logic [NREQ-1:0]     req__RDY,
  input  logic [NREQ-1:0]     req__ENA,
  input  logic [NREQ*DW-1:0]  req_v,
  output logic [DW-1:0]       ind_first,
  output logic [15:0]         ind_first_method,
  output logic                ind_notEmpty,
  output logic                RDY_ind_deq,
  input  logic                EN_ind_deq,
  input  logic                intr_enable,
  output logic                intr_status,
  output logic [31:0]         intr_channel,
  output logic                err_protocol
);
  localparam int IDX_W = $clog2(NREQ);

  typedef struct packed {
    logic [METHOD_W-1:0] method;
    logic [DW-1:0]       payload;
  } entry_t;

  logic             gnt_valid;
  logic [IDX_W-1:0] gnt_idx;
  logic             fifo_full;
  logic             fifo_empty;
  logic             enq;
  logic             deq;
  logic             ena_bad;
  logic             deq_bad;
  entry_t           wr_entry;
  entry_t           head;

`ifndef INDARB_FIXED_PRIO_EN
  logic [IDX_W-1:0] rr_ptr;
`endif

  // First wanting source at or after the search start, wrapping modulo NREQ.
  always_comb begin
    int idx;
    idx       = 0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
`ifdef INDARB_FIXED_PRIO_EN
      idx = k;
`else
      idx = (int'(rr_ptr) + k) % NREQ;
`endif
      if (!gnt_valid && req_want[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IDX_W'(idx);
      end
    end
  end

  always_comb begin
    req__RDY = '0;
    if (gnt_valid && !fifo_full) req__RDY[gnt_idx] = 1'b1;
  end

  // Only an exact one-hot match with the grant enqueues; anything else is a protocol error.
  assign enq     = (req__ENA != '0) && (req__ENA == req__RDY);
  assign ena_bad = (req__ENA != '0) && !enq;
  assign deq     = EN_ind_deq && !fifo_empty;
  assign deq_bad = EN_ind_deq && fifo_empty;

  assign wr_entry.method  = METHOD_W'(gnt_idx);
  assign wr_entry.payload = req_v[int'(gnt_idx)*DW +: DW];

`ifndef INDARB_FIXED_PRIO_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      rr_ptr <= '0;
    else if (enq)
      rr_ptr <= (int'(gnt_idx) == NREQ-1) ? '0 : gnt_idx + 1'b1;
  end
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      err_protocol <= 1'b0;
    else if (ena_bad || deq_bad)
      err_protocol <= 1'b1;
  end

  indarb_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst     (RST),
    .wr_en   (enq),
    .wr_data (wr_entry),
    .rd_en   (deq),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign ind_first        = head.payload;
  assign ind_first_method = head.method;
  assign ind_notEmpty     = !fifo_empty;
  assign RDY_ind_deq      = !fifo_empty;
  assign intr_status      = !fifo_empty && intr_enable;
  assign intr_channel     = intr_status ? {16'h0, head.method} : INTR_CHANNEL_NONE;
endmodule

// File: tb/tb_portal_indication_arbiter.sv
// Directed bench for portal_indication_arbiter (NREQ=4, DEPTH=8, DW=32).
module tb_portal_indication_arbiter;
  localparam int NREQ  = 4;
  localparam int DEPTH = 8;
  localparam int DW    = 32;

  logic               CLK;
  logic               RST;
  logic [NREQ-1:0]    req_want;
  logic [NREQ-1:0]    req__RDY;
  logic [NREQ-1:0]    req__ENA;
  logic [NREQ*DW-1:0] req_v;
  logic [DW-1:0]      ind_first;
  logic [15:0]        ind_first_method;
  logic               ind_notEmpty;
  logic               RDY_ind_deq;
  logic               EN_ind_deq;
  logic               intr_enable;
  logic               intr_status;
  logic [31:0]        intr_channel;
  logic               err_protocol;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  portal_indication_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH), .DW(DW)) dut (
    .CLK              (CLK),
    .RST              (RST),
    .req_want         (req_want),
    .req__RDY         (req__RDY),
    .req__ENA         (req__ENA),
    .req_v            (req_v),
    .ind_first        (ind_first),
    .ind_first_method (ind_first_method),
    .ind_notEmpty     (ind_notEmpty),
    .RDY_ind_deq      (RDY_ind_deq),
    .EN_ind_deq       (EN_ind_deq),
    .intr_enable      (intr_enable),
    .intr_status      (intr_status),
    .intr_channel     (intr_channel),
    .err_protocol     (err_protocol)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int exp_g;
    int prev_g;

    RST = 1'b1; req_want = '0; req__ENA = '0; req_v = '0;
    EN_ind_deq = 1'b0; intr_enable = 1'b0;
    #1;
    check("rst_chan",     intr_channel, 64'hFFFF_FFFF);
    check("rst_notempty", ind_notEmpty, 0);
    check("rst_rdydeq",   RDY_ind_deq,  0);
    check("rst_intr",     intr_status,  0);
    check("rst_err",      err_protocol, 0);
    step(); step();
    RST = 1'b0;
    step();
    check("idle_rdy",  req__RDY,     0);
    check("idle_chan", intr_channel, 64'hFFFF_FFFF);

    // single source 2
    intr_enable = 1'b1;
    req_want = 4'b0100;
    req_v[2*DW +: DW] = 32'hDEAD_BEEF;
    #1;
    check("s2_rdy", req__RDY, 4'b0100);
    req__ENA = 4'b0100;
    step();
    req__ENA = '0; req_want = '0;
    check("s2_first",    ind_first,        32'hDEAD_BEEF);
    check("s2_method",   ind_first_method, 2);
    check("s2_notempty", ind_notEmpty,     1);
    check("s2_rdydeq",   RDY_ind_deq,      1);
    check("s2_intr",     intr_status,      1);
    check("s2_chan",     intr_channel,     2);
    EN_ind_deq = 1'b1;
    step();
    EN_ind_deq = 1'b0;
    check("s2_deq_notempty", ind_notEmpty, 0);
    check("s2_deq_intr",     intr_status,  0);
    check("s2_deq_chan",     intr_channel, 64'hFFFF_FFFF);

    // all sources want; round-robin resumes after source 2
    for (int i = 0; i < NREQ; i++) req_v[i*DW +: DW] = 32'hA0 + i;
    req_want = 4'hF;
    prev_g = 0;
    for (int k = 0; k < 6; k++) begin
`ifdef INDARB_FIXED_PRIO_EN
      exp_g = 0;
`else
      exp_g = (3 + k) % NREQ;
`endif
      #1;
      check("rr_grant", req__RDY, 64'(1) << exp_g);
      if (k > 0) begin
        check("rr_head_method", ind_first_method, prev_g);
        check("rr_head_data",   ind_first,        32'hA0 + prev_g);
      end
      req__ENA = NREQ'(1 << exp_g);
      EN_ind_deq = (k > 0);
      step();
      prev_g = exp_g;
    end
    req__ENA = '0; req_want = '0;
    check("rr_last_method", ind_first_method, prev_g);
    EN_ind_deq = 1'b1;
    step();
    EN_ind_deq = 1'b0;
    check("rr_drained", ind_notEmpty, 0);
    check("rr_err",     err_protocol, 0);

    // fill to DEPTH from source 1
    req_want = 4'b0010;
    for (int k = 0; k < DEPTH; k++) begin
      req_v[1*DW +: DW] = 32'h100 + k;
      #1;
      check("fill_rdy", req__RDY, 4'b0010);
      req__ENA = 4'b0010;
      step();
      req__ENA = '0;
    end
    check("full_rdy",      req__RDY,     0);
    check("full_notempty", ind_notEmpty, 1);
    EN_ind_deq = 1'b1;
    #1;
    check("full_deq_no_bypass", req__RDY, 0);
    step();
    EN_ind_deq = 1'b0;
    check("after_full_rdy", req__RDY, 4'b0010);
    req_v[1*DW +: DW] = 32'h108;
    req__ENA = 4'b0010;
    step();
    req__ENA = '0; req_want = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      check("wrap_order",  ind_first,        32'h100 + k);
      check("wrap_method", ind_first_method, 1);
      EN_ind_deq = 1'b1;
      step();
      EN_ind_deq = 1'b0;
    end
    check("wrap_empty", ind_notEmpty, 0);
    check("wrap_err",   err_protocol, 0);

    // ENA to ungranted source
    req__ENA = 4'b0001;
    #1;
    check("bad_ena_rdy", req__RDY, 0);
    step();
    req__ENA = '0;
    check("bad_ena_err",   err_protocol, 1);
    check("bad_ena_empty", ind_notEmpty, 0);
    req_want = 4'b1000;
    req_v[3*DW +: DW] = 32'h33;
    #1;
    check("s3_rdy", req__RDY, 4'b1000);
    req__ENA = 4'b1000;
    step();
    req__ENA = '0;
    check("s3_first",      ind_first,    32'h33);
    check("err_sticky",    err_protocol, 1);
    // two ENA bits: nothing enqueued
    check("multi_rdy", req__RDY, 4'b1000);
    req__ENA = 4'b1001;
    step();
    req__ENA = '0; req_want = '0;
    check("multi_head", ind_first, 32'h33);
    EN_ind_deq = 1'b1;
    step();
    EN_ind_deq = 1'b0;
    check("multi_ignored", ind_notEmpty, 0);

    RST = 1'b1;
    #1;
    check("rst_clears_err", err_protocol, 0);
    step();
    RST = 1'b0;

    // deq while empty
    EN_ind_deq = 1'b1;
    step();
    EN_ind_deq = 1'b0;
    check("deq_empty_err",   err_protocol, 1);
    check("deq_empty_state", ind_notEmpty, 0);
    step();
    check("deq_empty_sticky", err_protocol, 1);

    // reset with 5 queued
    req_want = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      req_v[0 +: DW] = 32'h200 + k;
      req__ENA = 4'b0001;
      step();
    end
    req__ENA = '0; req_want = '0;
    check("q5_notempty", ind_notEmpty, 1);
    check("q5_head",     ind_first,    32'h200);
    #2;
    RST = 1'b1;
    #1;
    check("async_rst_notempty", ind_notEmpty, 0);
    check("async_rst_rdydeq",   RDY_ind_deq,  0);
    check("async_rst_chan",     intr_channel, 64'hFFFF_FFFF);
    check("async_rst_err",      err_protocol, 0);
    step();
    RST = 1'b0;
    req_want = 4'b0100;
    req_v[2*DW +: DW] = 32'h5A5A_0001;
    #1;
    check("post_rst_rdy", req__RDY, 4'b0100);
    req__ENA = 4'b0100;
    step();
    req__ENA = '0; req_want = '0;
    check("post_rst_first",  ind_first,        32'h5A5A_0001);
    check("post_rst_method", ind_first_method, 2);
    check("post_rst_chan",   intr_channel,     2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
